// File: rtl/lms_ctr_pkt_bridge_if.sv
// rtl/lms_ctr_pkt_bridge_if.sv - host byte stream, lms_ctr exfifo and status bundle for the packet bridge
//
// Groups every non-clock/reset signal of lms_ctr_pkt_bridge.
//   slave  : the bridge side (drives h_rx_ready, h_tx_*, if_d, if_rdempty, of_wrfull, rx_drop_cnt)
//   master : the surrounding host link / lms_ctr side
interface lms_ctr_pkt_bridge_if;
    logic [7:0]  h_rx_data;
    logic        h_rx_valid;
    logic        h_rx_ready;
    logic [7:0]  h_tx_data;
    logic        h_tx_valid;
    logic        h_tx_ready;
    logic [31:0] if_d;
    logic        if_rd;
    logic        if_rdempty;
    logic [31:0] of_d;
    logic        of_wr;
    logic        of_wrfull;
    logic        fifo_rst;
    logic [7:0]  rx_drop_cnt;

    modport slave (
        input  h_rx_data, h_rx_valid, output h_rx_ready,
        output h_tx_data, h_tx_valid, input  h_tx_ready,
        output if_d, input if_rd, output if_rdempty,
        input  of_d, of_wr, output of_wrfull,
        input  fifo_rst,
        output rx_drop_cnt
    );

    modport master (
        output h_rx_data, h_rx_valid, input  h_rx_ready,
        input  h_tx_data, h_tx_valid, output h_tx_ready,
        input  if_d, output if_rd, input if_rdempty,
        output of_d, of_wr, input of_wrfull,
        output fifo_rst,
        input  rx_drop_cnt
    );
endinterface

// File: rtl/lms_ctr_pkt_bridge.sv
// rtl/lms_ctr_pkt_bridge.sv - byte stream <-> 32-bit LMS64C packet bridge for lms_ctr
//
// RX: host bytes are packed little-endian into a PKT_WORDS x 32 buffer; only a complete
//     packet is exposed on the show-ahead if_d/if_rd/if_rdempty port. Partial packets left
//     idle for TIMEOUT_CYC cycles are discarded and counted in rx_drop_cnt (saturating).
// TX: a full reply packet is collected from of_d/of_wr (of_wrfull while sending) and then
//     streamed to the host as bytes, byte0 = d[7:0], with a registered h_tx_data/h_tx_valid.
// Ports: clk, reset_n (async active-low), bus (lms_ctr_pkt_bridge_if.slave).
// fifo_rst synchronously clears both paths but keeps rx_drop_cnt.
module lms_ctr_pkt_bridge #(
    parameter int PKT_WORDS   = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    lms_ctr_pkt_bridge_if.slave    bus
);
    localparam int AW = $clog2(PKT_WORDS);
    localparam int IW = $clog2(TIMEOUT_CYC);
    localparam logic [AW-1:0] LAST_WORD = AW'(PKT_WORDS - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

    typedef enum logic { RX_FILL, RX_HOLD } rx_state_e;
    typedef enum logic { TX_COLLECT, TX_SEND } tx_state_e;

    // RX state
    rx_state_e   rx_state_q, rx_state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [7:0]  drop_q, drop_d;
    logic [31:0] rx_buf_q [PKT_WORDS];
    logic [31:0] rx_buf_d [PKT_WORDS];

    // TX state
    tx_state_e   tx_state_q, tx_state_d;
    logic [AW-1:0] tx_wr_idx_q, tx_wr_idx_d;
    logic [AW-1:0] tx_rd_idx_q, tx_rd_idx_d;
    logic [1:0]  tx_lane_q, tx_lane_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] tx_buf_q [PKT_WORDS];
    logic [31:0] tx_buf_d [PKT_WORDS];

    logic [1:0]    tx_nxt_lane;
    logic [AW-1:0] tx_nxt_word;
    logic [31:0]   tx_nxt_w;

    // ------------------------------------------------------------------ RX
    always_comb begin
        rx_state_d = rx_state_q;
        byte_idx_d = byte_idx_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        idle_d     = idle_q;
        drop_d     = drop_q;
        rx_buf_d   = rx_buf_q;
        if (bus.fifo_rst) begin
            rx_state_d = RX_FILL;
            byte_idx_d = '0;
            wr_idx_d   = '0;
            rd_idx_d   = '0;
            idle_d     = '0;
        end else begin
            case (rx_state_q)
                RX_FILL: begin
                    if (bus.h_rx_valid) begin
                        // A transfer always beats a coincident timeout.
                        rx_buf_d[wr_idx_q][{byte_idx_q, 3'b000} +: 8] = bus.h_rx_data;
                        byte_idx_d = byte_idx_q + 2'd1;
                        idle_d     = '0;
                        if (byte_idx_q == 2'd3) begin
                            wr_idx_d = wr_idx_q + 1'b1;
                            if (wr_idx_q == LAST_WORD) begin
                                rx_state_d = RX_HOLD;
                            end
                        end
                    end else if ((byte_idx_q != 2'd0) || (wr_idx_q != '0)) begin
                        // idle_q holds the idle cycles already elapsed, so this is the
                        // TIMEOUT_CYC-th idle cycle of the partial packet.
                        if (idle_q == IDLE_LAST) begin
                            byte_idx_d = '0;
                            wr_idx_d   = '0;
                            idle_d     = '0;
                            if (drop_q != 8'hFF) begin
                                drop_d = drop_q + 8'd1;
                            end
                        end else begin
                            idle_d = idle_q + 1'b1;
                        end
                    end
                end
                RX_HOLD: begin
                    if (bus.if_rd) begin
                        rd_idx_d = rd_idx_q + 1'b1;
                        if (rd_idx_q == LAST_WORD) begin
                            rx_state_d = RX_FILL;
                        end
                    end
                end
                default: rx_state_d = RX_FILL;
            endcase
        end
    end

    assign bus.h_rx_ready  = (rx_state_q == RX_FILL);
    assign bus.if_rdempty  = (rx_state_q != RX_HOLD);
    assign bus.if_d        = (rx_state_q == RX_HOLD) ? rx_buf_q[rd_idx_q] : 32'h0;
    assign bus.rx_drop_cnt = drop_q;

    // ------------------------------------------------------------------ TX
    // Position and byte value of the next lane to present once the current one is taken.
    always_comb begin
        tx_nxt_lane = tx_lane_q + 2'd1;
        tx_nxt_word = tx_rd_idx_q + {{(AW-1){1'b0}}, (tx_lane_q == 2'd3)};
        tx_nxt_w    = tx_buf_q[tx_nxt_word];
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_wr_idx_d = tx_wr_idx_q;
        tx_rd_idx_d = tx_rd_idx_q;
        tx_lane_d   = tx_lane_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tx_buf_d    = tx_buf_q;
        if (bus.fifo_rst) begin
            tx_state_d  = TX_COLLECT;
            tx_wr_idx_d = '0;
            tx_rd_idx_d = '0;
            tx_lane_d   = '0;
            tx_data_d   = 8'h00;
            tx_valid_d  = 1'b0;
        end else begin
            case (tx_state_q)
                TX_COLLECT: begin
                    if (bus.of_wr) begin
                        tx_buf_d[tx_wr_idx_q] = bus.of_d;
                        tx_wr_idx_d = tx_wr_idx_q + 1'b1;
                        if (tx_wr_idx_q == LAST_WORD) begin
                            // Word 0 was written earlier, so its low byte is ready now.
                            tx_state_d  = TX_SEND;
                            tx_valid_d  = 1'b1;
                            tx_data_d   = tx_buf_q[0][7:0];
                            tx_rd_idx_d = '0;
                            tx_lane_d   = '0;
                        end
                    end
                end
                TX_SEND: begin
                    if (bus.h_tx_ready) begin
                        if ((tx_rd_idx_q == LAST_WORD) && (tx_lane_q == 2'd3)) begin
                            tx_state_d  = TX_COLLECT;
                            tx_valid_d  = 1'b0;
                            tx_data_d   = 8'h00;
                            tx_rd_idx_d = '0;
                            tx_lane_d   = '0;
                        end else begin
                            tx_lane_d   = tx_nxt_lane;
                            tx_rd_idx_d = tx_nxt_word;
                            tx_data_d   = tx_nxt_w[{tx_nxt_lane, 3'b000} +: 8];
                        end
                    end
                end
                default: tx_state_d = TX_COLLECT;
            endcase
        end
    end

    assign bus.of_wrfull  = (tx_state_q == TX_SEND);
    assign bus.h_tx_valid = tx_valid_q;
    assign bus.h_tx_data  = tx_data_q;

    // ------------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q  <= RX_FILL;
            byte_idx_q  <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            idle_q      <= '0;
            drop_q      <= 8'h00;
            tx_state_q  <= TX_COLLECT;
            tx_wr_idx_q <= '0;
            tx_rd_idx_q <= '0;
            tx_lane_q   <= '0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            byte_idx_q  <= byte_idx_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            idle_q      <= idle_d;
            drop_q      <= drop_d;
            tx_state_q  <= tx_state_d;
            tx_wr_idx_q <= tx_wr_idx_d;
            tx_rd_idx_q <= tx_rd_idx_d;
            tx_lane_q   <= tx_lane_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

    // Packet storage needs no reset: it is never visible before being fully written.
    always_ff @(posedge clk) begin
        rx_buf_q <= rx_buf_d;
        tx_buf_q <= tx_buf_d;
    end
endmodule
